// File: rtl/stage234_lane_dispatcher.sv
// Packs single-stream original-data messages into three-lane groups for the stage234 pipeline.
// A group issues when full, when a partial group times out, or on flush.
module stage234_lane_dispatcher #(
    parameter int unsigned DATA_W  = 264,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_en,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] out_data_1,
    output logic [DATA_W-1:0] out_data_2,
    output logic [DATA_W-1:0] out_data_3,
    output logic [2:0]        out_lane_mask,
    output logic [CNT_W-1:0]  out_group_cnt,
    output logic              busy
);

    localparam int unsigned TimerW = $clog2(TIMEOUT);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StIssue
    } state_e;

    state_e            state_q;
    logic [1:0]        fill_cnt_q;
    logic [TimerW-1:0] timer_q;

    logic accept;
    logic xfer;

    assign in_ready = (state_q != StIssue);
    assign accept   = in_valid & in_ready;
    assign xfer     = out_en & dn_ready;
    assign busy     = (fill_cnt_q != 2'd0) || (state_q == StIssue);

    // Lane registers double as the output bus so partially filled lanes are visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            fill_cnt_q    <= 2'd0;
            timer_q       <= '0;
            out_en        <= 1'b0;
            out_data_1    <= '0;
            out_data_2    <= '0;
            out_data_3    <= '0;
            out_lane_mask <= 3'b000;
            out_group_cnt <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        out_data_1    <= in_data;
                        out_lane_mask <= 3'b001;
                        fill_cnt_q    <= 2'd1;
                        timer_q       <= '0;
                        state_q       <= StFill;
                    end
                end

                StFill: begin
                    if (accept) begin
                        case (fill_cnt_q)
                            2'd1:    out_data_2 <= in_data;
                            2'd2:    out_data_3 <= in_data;
                            default: ;
                        endcase
                        out_lane_mask <= out_lane_mask | (3'b001 << fill_cnt_q);
                        fill_cnt_q    <= fill_cnt_q + 2'd1;
                        timer_q       <= '0;
                        // A same-cycle flush still includes the message just accepted.
                        if (fill_cnt_q == 2'd2 || flush) begin
                            state_q <= StIssue;
                            out_en  <= 1'b1;
                        end
                    end else if (flush || timer_q == TimerLast) begin
                        state_q <= StIssue;
                        out_en  <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TimerW'(1);
                    end
                end

                StIssue: begin
                    if (xfer) begin
                        out_en        <= 1'b0;
                        out_data_1    <= '0;
                        out_data_2    <= '0;
                        out_data_3    <= '0;
                        out_lane_mask <= 3'b000;
                        fill_cnt_q    <= 2'd0;
                        timer_q       <= '0;
                        out_group_cnt <= out_group_cnt + CNT_W'(1);
                        state_q       <= StIdle;
                    end
                end

                default: begin
                    state_q <= StIdle;
                    out_en  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage234_lane_dispatcher.sv
// Scoreboard bench: stimulus pushes expected groups, a negedge monitor pops them on each transfer.
// The counter is narrowed to 8 bits so the wrap is reached in a short run.
module tb_stage234_lane_dispatcher;

    localparam int unsigned DW = 264;
    localparam int unsigned TO = 16;
    localparam int unsigned CW = 8;

    typedef struct {
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic [DW-1:0] d3;
        logic [2:0]    mask;
        logic [CW-1:0] cnt;
    } grp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          flush;
    logic          out_en;
    logic          dn_ready;
    logic [DW-1:0] out_data_1;
    logic [DW-1:0] out_data_2;
    logic [DW-1:0] out_data_3;
    logic [2:0]    out_lane_mask;
    logic [CW-1:0] out_group_cnt;
    logic          busy;

    grp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] exp_cnt = '0;

    logic [DW-1:0] a_msg;
    logic [DW-1:0] b_msg;
    logic [DW-1:0] c_msg;
    logic [DW-1:0] zero;

    stage234_lane_dispatcher #(
        .DATA_W (DW),
        .TIMEOUT(TO),
        .CNT_W  (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .flush        (flush),
        .out_en       (out_en),
        .dn_ready     (dn_ready),
        .out_data_1   (out_data_1),
        .out_data_2   (out_data_2),
        .out_data_3   (out_data_3),
        .out_lane_mask(out_lane_mask),
        .out_group_cnt(out_group_cnt),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                        input logic [DW-1:0] d3, input logic [2:0] mask);
        grp_t g;
        g.d1   = d1;
        g.d2   = d2;
        g.d3   = d3;
        g.mask = mask;
        g.cnt  = exp_cnt;
        sb.push_back(g);
        exp_cnt = exp_cnt + CW'(1);
    endtask

    task automatic send(input logic [DW-1:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_wait: in_ready stuck at %b, expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    // Monitor: a transfer happens at the next posedge whenever out_en & dn_ready at negedge.
    initial begin
        grp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_en && dn_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_group: mask %b, none expected", out_lane_mask);
                end else begin
                    e = sb.pop_front();
                    chk("grp_lane1", out_data_1, e.d1);
                    chk("grp_lane2", out_data_2, e.d2);
                    chk("grp_lane3", out_data_3, e.d3);
                    chk("grp_mask", DW'(out_lane_mask), DW'(e.mask));
                    chk("grp_cnt", DW'(out_group_cnt), DW'(e.cnt));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a_msg = {24'h414E4E, {30{8'h5A}}};
        b_msg = {24'h414E53, {30{8'h3C}}};
        c_msg = DW'(1);
        zero  = '0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; dn_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_out_en", DW'(out_en), DW'(0));
        chk("rst_data1", out_data_1, zero);
        chk("rst_mask", DW'(out_lane_mask), DW'(0));
        chk("rst_cnt", DW'(out_group_cnt), DW'(0));
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_in_ready", DW'(in_ready), DW'(1));

        // Full group.
        push(a_msg, b_msg, c_msg, 3'b111);
        send(a_msg);
        chk("fill_lane1_visible", out_data_1, a_msg);
        send(b_msg);
        send(c_msg);
        chk("full_out_en", DW'(out_en), DW'(1));
        chk("full_in_ready", DW'(in_ready), DW'(0));
        chk("full_busy", DW'(busy), DW'(1));
        tick();
        chk("full_out_en_drop", DW'(out_en), DW'(0));
        chk("full_in_ready_back", DW'(in_ready), DW'(1));
        chk("full_cnt", DW'(out_group_cnt), DW'(1));
        chk("full_mask_clr", DW'(out_lane_mask), DW'(0));

        // Timeout: issue lands 16 edges after the accept edge.
        push(a_msg, zero, zero, 3'b001);
        send(a_msg);
        for (int i = 0; i < 15; i++) tick();
        chk("to_not_yet", DW'(out_en), DW'(0));
        tick();
        chk("to_out_en", DW'(out_en), DW'(1));
        chk("to_mask", DW'(out_lane_mask), DW'(3'b001));
        tick();
        chk("to_cnt", DW'(out_group_cnt), DW'(2));

        // Expiry race: accept while timer == TO-1 restarts the timer.
        push(a_msg, b_msg, zero, 3'b011);
        send(a_msg);
        for (int i = 0; i < 15; i++) tick();
        send(b_msg);
        chk("race_no_issue", DW'(out_en), DW'(0));
        chk("race_mask", DW'(out_lane_mask), DW'(3'b011));
        for (int i = 0; i < 15; i++) tick();
        chk("race_not_yet", DW'(out_en), DW'(0));
        tick();
        chk("race_out_en", DW'(out_en), DW'(1));
        tick();

        // Flush with two lanes buffered.
        push(a_msg, b_msg, zero, 3'b011);
        send(a_msg);
        send(b_msg);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_out_en", DW'(out_en), DW'(1));
        tick();
        // Flush in IDLE is ignored.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_idle_out_en", DW'(out_en), DW'(0));
        chk("flush_idle_busy", DW'(busy), DW'(0));
        tick();
        chk("flush_idle_out_en2", DW'(out_en), DW'(0));
        // Flush coincident with second accept.
        push(a_msg, b_msg, zero, 3'b011);
        send(a_msg);
        flush = 1'b1;
        send(b_msg);
        flush = 1'b0;
        chk("flush_acc_out_en", DW'(out_en), DW'(1));
        chk("flush_acc_mask", DW'(out_lane_mask), DW'(3'b011));
        tick();

        // Backpressure.
        dn_ready = 1'b0;
        push(b_msg, c_msg, a_msg, 3'b111);
        send(b_msg);
        send(c_msg);
        send(a_msg);
        in_valid = 1'b1;
        in_data  = c_msg;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_out_en", DW'(out_en), DW'(1));
            chk("bp_in_ready", DW'(in_ready), DW'(0));
            chk("bp_lane3", out_data_3, a_msg);
        end
        in_valid = 1'b0;
        dn_ready = 1'b1;
        tick();
        chk("bp_out_en_drop", DW'(out_en), DW'(0));
        chk("bp_cnt", DW'(out_group_cnt), DW'(6));
        chk("bp_mask", DW'(out_lane_mask), DW'(0));
        tick();
        chk("bp_single", DW'(out_group_cnt), DW'(6));

        // Reset while a group waits in ISSUE.
        dn_ready = 1'b0;
        send(a_msg);
        send(b_msg);
        send(c_msg);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dn_ready = 1'b1;
        exp_cnt = '0;
        chk("rstop_out_en", DW'(out_en), DW'(0));
        chk("rstop_data3", out_data_3, zero);
        chk("rstop_mask", DW'(out_lane_mask), DW'(0));
        chk("rstop_cnt", DW'(out_group_cnt), DW'(0));
        chk("rstop_in_ready", DW'(in_ready), DW'(1));
        tick();
        chk("rstop_no_issue", DW'(out_en), DW'(0));

        // Counter wrap: 2^CW full groups at 3 messages per 4 cycles.
        for (int g = 0; g < (1 << CW); g++) begin
            push(DW'(3 * g + 1), DW'(3 * g + 2), DW'(3 * g + 3), 3'b111);
            send(DW'(3 * g + 1));
            send(DW'(3 * g + 2));
            send(DW'(3 * g + 3));
            tick();
        end
        chk("wrap_cnt", DW'(out_group_cnt), DW'(0));
        tick();
        tick();
        chk("sb_drain", DW'(sb.size()), DW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage234_lane_dispatcher.md
Name: stage234_lane_dispatcher

Overview:
- Collects original-data messages from a single upstream stream and packs them into three-lane groups for the stage234 message pipeline.
- Drives `original_data_1..3` and `message_en_in` of the stage pipeline.
- Issues a group when all three lanes are full, when a partial group has waited `TIMEOUT` cycles, or on explicit flush.
- Unused lanes are driven all-zero, which the stage pipeline treats as an idle lane.

Parameters:
- DATA_W, 264, width of one original-data message (matches `MAX_ORIGINAL_DATA_BITS`).
- TIMEOUT, 16, idle cycles a partial group waits before forced issue; legal range 2..255.
- CNT_W, 16, width of the issued-group counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  upstream message valid.
- in_ready  out  1  dispatcher can accept a message this cycle.
- in_data  in  DATA_W  upstream message.
- flush  in  1  force issue of any partial group.
- out_en  out  1  group valid; connects to `message_en_in`.
- dn_ready  in  1  stage pipeline accepts the group this cycle.
- out_data_1  out  DATA_W  lane 1 message.
- out_data_2  out  DATA_W  lane 2 message.
- out_data_3  out  DATA_W  lane 3 message.
- out_lane_mask  out  3  bit k-1 = lane k holds a real message.
- out_group_cnt  out  CNT_W  number of groups issued, wraps.
- busy  out  1  fill_cnt != 0 or state == ISSUE.

Behaviour:
- Reset (rst high at a clk edge):
  - state = IDLE, fill_cnt = 0, timer = 0.
  - out_en = 0, out_data_1..3 = 0, out_lane_mask = 3'b000, out_group_cnt = 0, busy = 0.
  - in_ready reads 1 the cycle after rst deasserts.
  - Reset mid-operation discards buffered lanes and any pending group without issuing it.
- Handshake:
  - Upstream accept = in_valid & in_ready.
  - Downstream transfer = out_en & dn_ready.
  - in_ready is a combinational decode of state only: 1 in IDLE and FILL, 0 in ISSUE.
  - in_ready never depends on in_valid.
- Lane fill:
  - An accepted message is registered into lane[fill_cnt + 1].
  - The matching out_lane_mask bit is set and fill_cnt increments, all on the same edge.
  - Lanes fill strictly in order 1, 2, 3.
  - out_data lanes are the lane registers themselves and are visible while filling.
- States:
  - IDLE (fill_cnt = 0): accept -> FILL (fill_cnt = 1). flush is ignored.
  - FILL (fill_cnt 1..2):
    - Accept resets timer to 0; if fill_cnt reaches 3 -> ISSUE.
    - No accept: timer increments.
    - When timer == TIMEOUT-1 with no accept -> ISSUE.
    - flush high -> ISSUE on that edge. An accept in the same cycle is taken first, so that message is included.
  - ISSUE: out_en = 1, in_ready = 0, group contents frozen.
    - On transfer: lanes cleared to 0, mask = 0, fill_cnt = 0, timer = 0, out_group_cnt += 1 (mod 2^CNT_W), next state IDLE.
    - out_en is 0 in the cycle after transfer.
    - dn_ready low holds ISSUE indefinitely with all outputs stable.
- Latency:
  - Third message accepted on edge t -> out_en high from t.
  - With dn_ready = 1, transfer at edge t+1 and in_ready high again after t+1.
  - Sustained throughput: 3 messages per 4 cycles.
- Timeout boundary:
  - An accept on the exact expiry cycle wins; timer restarts and no issue occurs.
  - The timer counts only in FILL.
- Widths:
  - timer is ceil(log2(TIMEOUT)) bits.
  - fill_cnt is 2 bits and never exceeds 3.

Test Plan:
- **Full group:** rst for 2 cycles, then 3 back-to-back messages A = 0x414E4E…, B = 0x414E53…, C = 0x1 with dn_ready = 1.
  - out_en high for exactly 1 cycle; out_data_1..3 = A, B, C; out_lane_mask = 3'b111.
  - out_group_cnt goes 0 -> 1; in_ready low only during ISSUE.
- **Timeout:** one message A, then in_valid = 0, TIMEOUT = 16.
  - out_en rises 16 cycles after A's accept edge, with out_lane_mask = 3'b001 and out_data_2 = out_data_3 = 0.
- **Expiry race:** message at timer == 15 (TIMEOUT = 16).
  - No issue occurs; fill_cnt = 2, timer = 0; issue happens 16 cycles later with mask 3'b011.
- **Flush:** flush with 2 buffered lanes issues mask 3'b011 on the next cycle. flush in IDLE produces no out_en. flush coincident with the 2nd accept issues mask 3'b011 including that message.
- **Backpressure:** dn_ready = 0 for 10 cycles while in ISSUE.
  - out_en and data stable; in_ready = 0; in_valid held high is not accepted.
  - dn_ready = 1 gives exactly one transfer.
- **Reset mid-op and wrap:** rst asserted in ISSUE -> all outputs 0 and no transfer counted. Then 65536 full groups -> out_group_cnt wraps to 0.
